rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_arb_pkg.sv | 44 ++++
 rtl/rf_write_arbiter_if.sv | 38 +++
 rtl/rf_wr_slot.sv | 44 ++++
 rtl/rf_write_arbiter.sv | 119 +++++++++++
 tb/tb_rf_write_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_arb_pkg.sv
// Shared constants and helpers for the register-file write arbiter.
package rf_arb_pkg;

  localparam int NUM_SIDE = 3;

  // Side requester indices.
  localparam int ISR  = 0;  // interrupt PC save
  localparam int NET  = 1;  // network status
  localparam int RAND = 2;  // random-number refresh

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  localparam int DEFAULT_STARVE_LIMIT = 8;

  // Wait counter must be able to hold the value STARVE_LIMIT itself.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_STARVE_LIMIT);

  // Round-robin pick: first requesting index at or after ptr, wrapping.
  // Returns ptr when nothing requests; callers only use it when req != 0.
  function automatic logic [1:0] rr_pick(input logic [NUM_SIDE-1:0] req,
                                         input logic [1:0]          ptr);
    logic [1:0] idx;
    logic [1:0] cand;
    logic       found;
    int         c;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_SIDE; k++) begin
      c    = (int'(ptr) + k) % NUM_SIDE;
      cand = 2'(c);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bus between the pipeline/side requesters and the write arbiter.
//
// Side handshake: a requester raises SIDE_VALID[i] with SIDE_ADDR[i] and
// SIDE_DATA[i] and holds all three stable until a rising edge where
// SIDE_READY[i] is also high; that edge transfers the request. WB_VALID has
// no ready: the pipeline holds WB_* stable for as long as STALL is high,
// and a WB request is consumed on any edge where STALL is low.
interface rf_write_arbiter_if;
  import rf_arb_pkg::*;

  logic                             WB_VALID;
  logic [ADDR_W-1:0]                WB_ADDR;
  logic [DATA_W-1:0]                WB_DATA;
  logic                             STALL;

  logic [NUM_SIDE-1:0]              SIDE_VALID;
  logic [NUM_SIDE-1:0][ADDR_W-1:0]  SIDE_ADDR;
  logic [NUM_SIDE-1:0][DATA_W-1:0]  SIDE_DATA;
  logic [NUM_SIDE-1:0]              SIDE_READY;

  logic                             WR_EN;
  logic [ADDR_W-1:0]                WR_ADDR;
  logic [DATA_W-1:0]                WR_DATA;
  logic                             BUSY;

  // Requesters / pipeline side.
  modport master (
    output WB_VALID, WB_ADDR, WB_DATA, SIDE_VALID, SIDE_ADDR, SIDE_DATA,
    input  STALL, SIDE_READY, WR_EN, WR_ADDR, WR_DATA, BUSY
  );

  // Arbiter side.
  modport slave (
    input  WB_VALID, WB_ADDR, WB_DATA, SIDE_VALID, SIDE_ADDR, SIDE_DATA,
    output STALL, SIDE_READY, WR_EN, WR_ADDR, WR_DATA, BUSY
  );

endinterface

// File: rtl/rf_wr_slot.sv
// One side-requester holding slot: buffered addr/data, wait counter and
// starved flag. A capture and a grant never coincide because capture
// needs the slot empty and grant needs it full.
module rf_wr_slot import rf_arb_pkg::*; #(
  parameter int LIMIT = DEFAULT_STARVE_LIMIT,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              grant,
  output logic              full,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              starved
);

  logic [CNT_W-1:0] wait_cnt;

  // Slot fill/free and saturating wait count while full and not granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      addr     <= '0;
      data     <= '0;
      wait_cnt <= '0;
    end else if (grant) begin
      full     <= 1'b0;
      wait_cnt <= '0;
    end else if (cap) begin
      full     <= 1'b1;
      addr     <= cap_addr;
      data     <= cap_data;
      wait_cnt <= '0;
    end else if (full && (wait_cnt != CNT_W'(LIMIT))) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign starved = full && (wait_cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/rf_write_arbiter.sv
// Single-port register-file write arbiter: pipeline writeback versus three
// buffered side requesters, with starvation pre-emption and round-robin
// among slots. The winner of cycle t is registered onto WR_* at its end.
module rf_write_arbiter import rf_arb_pkg::*; #(
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
  parameter bit ZERO_PROTECT = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  rf_write_arbiter_if.slave bus
);

  localparam int CNT_W = cnt_width(STARVE_LIMIT);

  logic [NUM_SIDE-1:0]             full;
  logic [NUM_SIDE-1:0]             starved;
  logic [NUM_SIDE-1:0]             cap;
  logic [NUM_SIDE-1:0]             grant;
  logic [NUM_SIDE-1:0][ADDR_W-1:0] slot_addr;
  logic [NUM_SIDE-1:0][DATA_W-1:0] slot_data;

  logic [1:0]        rr_ptr;
  logic [1:0]        pick_idx;
  logic              win;
  logic              win_slot;
  logic              stall;
  logic              suppress;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  assign cap = bus.SIDE_VALID & bus.SIDE_READY;

  for (genvar i = 0; i < NUM_SIDE; i++) begin : g_slot
    rf_wr_slot #(
      .LIMIT (STARVE_LIMIT),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk      (CLK),
      .rst_n    (RESET),
      .cap      (cap[i]),
      .cap_addr (bus.SIDE_ADDR[i]),
      .cap_data (bus.SIDE_DATA[i]),
      .grant    (grant[i]),
      .full     (full[i]),
      .addr     (slot_addr[i]),
      .data     (slot_data[i]),
      .starved  (starved[i])
    );
  end

  // Priority: starved slots, then writeback, then any full slot.
  always_comb begin
    win      = 1'b0;
    win_slot = 1'b0;
    stall    = 1'b0;
    pick_idx = rr_ptr;
    grant    = '0;
    win_addr = '0;
    win_data = '0;
    if (|starved) begin
      pick_idx = rr_pick(starved, rr_ptr);
      win      = 1'b1;
      win_slot = 1'b1;
      stall    = bus.WB_VALID;
    end else if (bus.WB_VALID) begin
      win      = 1'b1;
      win_addr = bus.WB_ADDR;
      win_data = bus.WB_DATA;
    end else if (|full) begin
      pick_idx = rr_pick(full, rr_ptr);
      win      = 1'b1;
      win_slot = 1'b1;
    end
    if (win_slot) begin
      grant[pick_idx] = 1'b1;
      win_addr        = slot_addr[pick_idx];
      win_data        = slot_data[pick_idx];
    end
    // A zero-address winner is still consumed, just never written.
    suppress = ZERO_PROTECT && (win_addr == '0);
  end

  // Round-robin pointer moves past each granted slot.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rr_ptr <= 2'd0;
    end else if (win_slot) begin
      rr_ptr <= (pick_idx == 2'(NUM_SIDE - 1)) ? 2'd0 : pick_idx + 2'd1;
    end
  end

  // Write-port registers; addr/data hold their value when nothing writes.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= win && !suppress;
      if (win && !suppress) begin
        wr_addr_q <= win_addr;
        wr_data_q <= win_data;
      end
    end
  end

  assign bus.WR_EN      = wr_en_q;
  assign bus.WR_ADDR    = wr_addr_q;
  assign bus.WR_DATA    = wr_data_q;
  assign bus.STALL      = stall;
  assign bus.BUSY       = |full;
  // Held low during reset so nothing is accepted until reset releases.
  assign bus.SIDE_READY = ~full & {NUM_SIDE{RESET}};

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus a randomized run
// checked against a cycle-level reference model.
module tb_rf_write_arbiter;

  localparam int LIMIT = 8;

  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  rf_write_arbiter_if bus();

  rf_write_arbiter #(
    .STARVE_LIMIT (LIMIT),
    .ZERO_PROTECT (1'b1)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [36:0] exp_q[$];
  logic [31:0] regfile [32];

  // Register-file image built from the write port.
  always @(negedge CLK) begin
    if (bus.WR_EN === 1'b1) regfile[bus.WR_ADDR] = bus.WR_DATA;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs;
    bus.WB_VALID   = 1'b0;
    bus.WB_ADDR    = '0;
    bus.WB_DATA    = '0;
    bus.SIDE_VALID = '0;
    bus.SIDE_ADDR  = '0;
    bus.SIDE_DATA  = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    RESET = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
    #1;
  endtask

  // Reference round-robin choice among candidates, -1 if none.
  function automatic int pick(input bit [2:0] cand, input int ptr);
    for (int k = 0; k < 3; k++) begin
      if (cand[(ptr + k) % 3]) return (ptr + k) % 3;
    end
    return -1;
  endfunction

  task automatic test_reset;
    idle_inputs();
    RESET = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus.WR_EN !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b want 0", bus.WR_EN); end
    n_cmp++; if (bus.WR_ADDR !== 5'd0) begin n_fail++; $display("FAIL rst_wr_addr: got %0d want 0", bus.WR_ADDR); end
    n_cmp++; if (bus.WR_DATA !== 32'd0) begin n_fail++; $display("FAIL rst_wr_data: got %h want 0", bus.WR_DATA); end
    n_cmp++; if (bus.SIDE_READY !== 3'b000) begin n_fail++; $display("FAIL rst_side_ready: got %b want 000", bus.SIDE_READY); end
    n_cmp++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.BUSY); end
    n_cmp++; if (bus.STALL !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", bus.STALL); end
    RESET = 1'b1;
    #1;
    n_cmp++; if (bus.SIDE_READY !== 3'b111) begin n_fail++; $display("FAIL rst_release_ready: got %b want 111", bus.SIDE_READY); end
  endtask

  task automatic test_wb_basic;
    do_reset();
    bus.WB_VALID = 1'b1;
    bus.WB_ADDR  = 5'd5;
    bus.WB_DATA  = 32'hDEADBEEF;
    #1;
    n_cmp++; if (bus.STALL !== 1'b0) begin n_fail++; $display("FAIL wb_stall: got %b want 0", bus.STALL); end
    tick();
    n_cmp++; if (bus.WR_EN !== 1'b1) begin n_fail++; $display("FAIL wb_en: got %b want 1", bus.WR_EN); end
    n_cmp++; if (bus.WR_ADDR !== 5'd5) begin n_fail++; $display("FAIL wb_addr: got %0d want 5", bus.WR_ADDR); end
    n_cmp++; if (bus.WR_DATA !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wb_data: got %h want deadbeef", bus.WR_DATA); end
    bus.WB_VALID = 1'b0;
    tick();
    n_cmp++; if (bus.WR_EN !== 1'b0) begin n_fail++; $display("FAIL idle_en: got %b want 0", bus.WR_EN); end
    n_cmp++; if (bus.WR_ADDR !== 5'd5 || bus.WR_DATA !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL idle_hold: got %0d/%h want 5/deadbeef", bus.WR_ADDR, bus.WR_DATA);
    end
  endtask

  task automatic test_zero_protect;
    do_reset();
    bus.WB_VALID = 1'b1;
    bus.WB_ADDR  = 5'd9;
    bus.WB_DATA  = 32'h99;
    tick();
    bus.WB_ADDR  = 5'd0;
    bus.WB_DATA  = 32'h1234;
    #1;
    n_cmp++; if (bus.STALL !== 1'b0) begin n_fail++; $display("FAIL zero_stall: got %b want 0", bus.STALL); end
    tick();
    n_cmp++; if (bus.WR_EN !== 1'b0) begin n_fail++; $display("FAIL zero_en: got %b want 0", bus.WR_EN); end
    n_cmp++; if (bus.WR_ADDR !== 5'd9 || bus.WR_DATA !== 32'h99) begin
      n_fail++; $display("FAIL zero_hold: got %0d/%h want 9/99", bus.WR_ADDR, bus.WR_DATA);
    end
    bus.WB_VALID = 1'b0;
  endtask

  task automatic test_side_rr;
    logic [4:0]  ea[3];
    logic [31:0] ed[3];
    logic [2:0]  er[3];
    ea = '{5'd30, 5'd29, 5'd31};
    ed = '{32'hA0, 32'hA1, 32'hA2};
    er = '{3'b001, 3'b011, 3'b111};
    do_reset();
    n_cmp++; if (bus.SIDE_READY !== 3'b111) begin n_fail++; $display("FAIL rr_ready0: got %b want 111", bus.SIDE_READY); end
    bus.SIDE_VALID = 3'b111;
    for (int i = 0; i < 3; i++) begin
      bus.SIDE_ADDR[i] = ea[i];
      bus.SIDE_DATA[i] = ed[i];
    end
    tick();
    bus.SIDE_VALID = 3'b000;
    n_cmp++; if (bus.SIDE_READY !== 3'b000) begin n_fail++; $display("FAIL rr_ready_full: got %b want 000", bus.SIDE_READY); end
    n_cmp++; if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL rr_busy: got %b want 1", bus.BUSY); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus.WR_EN !== 1'b1 || bus.WR_ADDR !== ea[i] || bus.WR_DATA !== ed[i]) begin
        n_fail++; $display("FAIL rr_write%0d: got %b/%0d/%h want 1/%0d/%h", i, bus.WR_EN, bus.WR_ADDR, bus.WR_DATA, ea[i], ed[i]);
      end
      n_cmp++; if (bus.SIDE_READY !== er[i]) begin n_fail++; $display("FAIL rr_ready%0d: got %b want %b", i, bus.SIDE_READY, er[i]); end
    end
    n_cmp++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL rr_busy_end: got %b want 0", bus.BUSY); end
    tick();
    n_cmp++; if (bus.WR_EN !== 1'b0) begin n_fail++; $display("FAIL rr_idle: got %b want 0", bus.WR_EN); end
  endtask

  task automatic test_starve;
    do_reset();
    bus.WB_VALID      = 1'b1;
    bus.WB_ADDR       = 5'd7;
    bus.WB_DATA       = 32'h1000;
    bus.SIDE_VALID[1] = 1'b1;
    bus.SIDE_ADDR[1]  = 5'd29;
    bus.SIDE_DATA[1]  = 32'h5;
    tick();
    bus.SIDE_VALID = '0;
    n_cmp++; if (bus.WR_EN !== 1'b1 || bus.WR_DATA !== 32'h1000) begin
      n_fail++; $display("FAIL starve_wb0: got %b/%h want 1/1000", bus.WR_EN, bus.WR_DATA);
    end
    for (int k = 1; k <= LIMIT; k++) begin
      bus.WB_DATA = 32'h1000 + 32'(k);
      #1;
      n_cmp++; if (bus.STALL !== 1'b0) begin n_fail++; $display("FAIL starve_wait%0d_stall: got %b want 0", k, bus.STALL); end
      tick();
      n_cmp++; if (bus.WR_EN !== 1'b1 || bus.WR_ADDR !== 5'd7 || bus.WR_DATA !== 32'h1000 + 32'(k)) begin
        n_fail++; $display("FAIL starve_wait%0d_wr: got %b/%0d/%h want 1/7/%h", k, bus.WR_EN, bus.WR_ADDR, bus.WR_DATA, 32'h1000 + 32'(k));
      end
    end
    bus.WB_DATA = 32'h2000;
    #1;
    n_cmp++; if (bus.STALL !== 1'b1) begin n_fail++; $display("FAIL starve_stall: got %b want 1", bus.STALL); end
    tick();
    n_cmp++; if (bus.WR_EN !== 1'b1 || bus.WR_ADDR !== 5'd29 || bus.WR_DATA !== 32'h5) begin
      n_fail++; $display("FAIL starve_slot_wr: got %b/%0d/%h want 1/29/5", bus.WR_EN, bus.WR_ADDR, bus.WR_DATA);
    end
    n_cmp++; if (bus.STALL !== 1'b0) begin n_fail++; $display("FAIL starve_stall_once: got %b want 0", bus.STALL); end
    n_cmp++; if (bus.SIDE_READY !== 3'b111) begin n_fail++; $display("FAIL starve_ready: got %b want 111", bus.SIDE_READY); end
    tick();
    n_cmp++; if (bus.WR_EN !== 1'b1 || bus.WR_ADDR !== 5'd7 || bus.WR_DATA !== 32'h2000) begin
      n_fail++; $display("FAIL starve_resume: got %b/%0d/%h want 1/7/2000", bus.WR_EN, bus.WR_ADDR, bus.WR_DATA);
    end
    bus.WB_VALID = 1'b0;
  endtask

  task automatic test_same_addr;
    do_reset();
    bus.SIDE_VALID[0] = 1'b1;
    bus.SIDE_ADDR[0]  = 5'd30;
    bus.SIDE_DATA[0]  = 32'h100;
    tick();
    bus.SIDE_VALID = '0;
    bus.WB_VALID   = 1'b1;
    bus.WB_ADDR    = 5'd30;
    bus.WB_DATA    = 32'h200;
    tick();
    bus.WB_VALID = 1'b0;
    n_cmp++; if (bus.WR_EN !== 1'b1 || bus.WR_ADDR !== 5'd30 || bus.WR_DATA !== 32'h200) begin
      n_fail++; $display("FAIL same_first: got %b/%0d/%h want 1/30/200", bus.WR_EN, bus.WR_ADDR, bus.WR_DATA);
    end
    tick();
    n_cmp++; if (bus.WR_EN !== 1'b1 || bus.WR_ADDR !== 5'd30 || bus.WR_DATA !== 32'h100) begin
      n_fail++; $display("FAIL same_second: got %b/%0d/%h want 1/30/100", bus.WR_EN, bus.WR_ADDR, bus.WR_DATA);
    end
    tick();
    n_cmp++; if (regfile[30] !== 32'h100) begin n_fail++; $display("FAIL same_final: got %h want 100", regfile[30]); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    bus.SIDE_VALID = 3'b111;
    bus.SIDE_ADDR  = {5'd31, 5'd29, 5'd30};
    bus.SIDE_DATA  = {32'hC2, 32'hC1, 32'hC0};
    bus.WB_VALID   = 1'b1;
    bus.WB_ADDR    = 5'd3;
    bus.WB_DATA    = 32'h33;
    tick();
    bus.SIDE_VALID = '0;
    n_cmp++; if (bus.BUSY !== 1'b1 || bus.WR_EN !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre: got busy %b en %b want 1 1", bus.BUSY, bus.WR_EN);
    end
    RESET = 1'b0;
    #1;
    n_cmp++; if (bus.WR_EN !== 1'b0) begin n_fail++; $display("FAIL mid_en: got %b want 0", bus.WR_EN); end
    n_cmp++; if (bus.BUSY !== 1'b0 || bus.SIDE_READY !== 3'b000 || bus.STALL !== 1'b0) begin
      n_fail++; $display("FAIL mid_flags: got busy %b ready %b stall %b want 0 000 0", bus.BUSY, bus.SIDE_READY, bus.STALL);
    end
    bus.WB_VALID = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
    #1;
    n_cmp++; if (bus.SIDE_READY !== 3'b111) begin n_fail++; $display("FAIL mid_ready: got %b want 111", bus.SIDE_READY); end
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++; if (bus.WR_EN !== 1'b0) begin n_fail++; $display("FAIL mid_stale%0d: got %b want 0", k, bus.WR_EN); end
    end
  endtask

  task automatic test_random;
    bit          m_full[3];
    logic [4:0]  m_addr[3];
    logic [31:0] m_data[3];
    int          m_age[3];
    int          m_ptr;
    bit          prev_stall;
    bit [2:0]    acc_prev;
    bit [2:0]    exp_ready;
    bit [2:0]    cand_s;
    bit [2:0]    cand_f;
    bit          exp_stall;
    bit          exp_busy;
    int          w;
    bit          wb_win;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  last_addr;
    logic [31:0] last_data;
    logic [36:0] e;

    do_reset();
    for (int i = 0; i < 3; i++) begin
      m_full[i] = 0; m_addr[i] = '0; m_data[i] = '0; m_age[i] = 0;
    end
    m_ptr = 0; prev_stall = 0; acc_prev = '0;
    last_addr = '0; last_data = '0;
    exp_q.delete();

    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!prev_stall) begin
        bus.WB_VALID = ($urandom_range(0, 3) != 0);
        bus.WB_ADDR  = 5'($urandom_range(0, 31));
        bus.WB_DATA  = $urandom;
      end
      for (int i = 0; i < 3; i++) begin
        if (!(bus.SIDE_VALID[i] && !acc_prev[i])) begin
          bus.SIDE_VALID[i] = ($urandom_range(0, 5) == 0);
          bus.SIDE_ADDR[i]  = 5'($urandom_range(0, 31));
          bus.SIDE_DATA[i]  = $urandom;
        end
      end
      #1;
      for (int i = 0; i < 3; i++) begin
        exp_ready[i] = !m_full[i];
        cand_s[i]    = m_full[i] && (m_age[i] >= LIMIT);
        cand_f[i]    = m_full[i];
      end
      exp_busy  = m_full[0] | m_full[1] | m_full[2];
      exp_stall = 0;
      wb_win    = 0;
      w = pick(cand_s, m_ptr);
      if (w >= 0) exp_stall = bus.WB_VALID;
      else if (bus.WB_VALID) wb_win = 1;
      else w = pick(cand_f, m_ptr);

      n_cmp++; if (bus.SIDE_READY !== exp_ready) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, bus.SIDE_READY, exp_ready); end
      n_cmp++; if (bus.STALL !== exp_stall) begin n_fail++; $display("FAIL rnd_stall c%0d: got %b want %b", cyc, bus.STALL, exp_stall); end
      n_cmp++; if (bus.BUSY !== exp_busy) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b want %b", cyc, bus.BUSY, exp_busy); end

      wa = '0; wd = '0;
      if (wb_win) begin wa = bus.WB_ADDR; wd = bus.WB_DATA; end
      else if (w >= 0) begin wa = m_addr[w]; wd = m_data[w]; end
      if ((wb_win || w >= 0) && wa != 5'd0) exp_q.push_back({wa, wd});

      for (int i = 0; i < 3; i++) begin
        acc_prev[i] = bus.SIDE_VALID[i] && exp_ready[i];
        if (!wb_win && w == i) begin
          m_full[i] = 0; m_age[i] = 0; m_ptr = (i + 1) % 3;
        end else if (m_full[i]) begin
          if (m_age[i] < LIMIT) m_age[i]++;
        end else if (acc_prev[i]) begin
          m_full[i] = 1; m_addr[i] = bus.SIDE_ADDR[i]; m_data[i] = bus.SIDE_DATA[i]; m_age[i] = 0;
        end
      end
      prev_stall = exp_stall;

      tick();
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        last_addr = e[36:32];
        last_data = e[31:0];
        n_cmp++; if (bus.WR_EN !== 1'b1 || bus.WR_ADDR !== last_addr || bus.WR_DATA !== last_data) begin
          n_fail++; $display("FAIL rnd_write c%0d: got %b/%0d/%h want 1/%0d/%h", cyc, bus.WR_EN, bus.WR_ADDR, bus.WR_DATA, last_addr, last_data);
        end
      end else begin
        n_cmp++; if (bus.WR_EN !== 1'b0 || bus.WR_ADDR !== last_addr || bus.WR_DATA !== last_data) begin
          n_fail++; $display("FAIL rnd_nowrite c%0d: got %b/%0d/%h want 0/%0d/%h", cyc, bus.WR_EN, bus.WR_ADDR, bus.WR_DATA, last_addr, last_data);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_wb_basic();
    test_zero_protect();
    test_side_rr();
    test_starve();
    test_same_addr();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
